prime_trial_divider: RTL and testbench
======================================

Name: prime_trial_divider

Overview:
- Sequential trial-division prime tester for the seconds-demo design.
- Latches a test number on `start` and divides it by 2, 3, 5, 7, … while d*d <= N.
- Reports prime/composite and the smallest factor.
- Drives `stop_counter`, which is the `StopCounter` input of the seconds counter: the counter runs while this block works and freezes once the result is final.

Parameters:
- WIDTH, 16, bit width of the test number, divisor, factor and remainder datapath.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- test_number  in  WIDTH  number to test; sampled on the edge that accepts `start`
- busy  out  1  high from the accepting edge until DONE is entered
- done  out  1  high while in DONE (result valid)
- is_prime  out  1  result; valid only while `done`=1
- factor  out  WIDTH  smallest divisor found; 0 if N is prime or N<2
- stop_counter  out  1  equals `done`; feeds the counter's StopCounter input

Behaviour:
- Reset:
  - Reset is asynchronous on rst_n=0.
  - State returns to IDLE; busy, done, is_prime, stop_counter, factor and all internal registers go to 0.
  - Reset mid-operation aborts the test immediately; no partial result is kept.
- States: IDLE, SQCHK, DIV, DONE.
- IDLE, on start=1:
  - Latch N=test_number and set d=2.
  - If N<2: go to DONE with is_prime=0, factor=0.
  - Otherwise go to SQCHK.
- SQCHK:
  - Compute d*d at 2*WIDTH bits (no overflow).
  - If d*d > N: go to DONE with is_prime=1, factor=0.
  - Otherwise pulse start to the mod unit with (N, d) and go to DIV.
- DIV:
  - Wait for the mod unit's valid, which arrives exactly WIDTH+1 cycles after its start.
  - On valid with remainder=0: go to DONE with is_prime=0, factor=d.
  - On valid with nonzero remainder: update d (d=2 becomes 3, otherwise d+2) and return to SQCHK.
- DONE:
  - done and stop_counter are held high and outputs are held stable.
  - A new start restarts exactly as from IDLE: done and stop_counter fall on that same edge.
- `start` while busy is ignored. `test_number` changes while busy have no effect.
- Latency L counts edges, including the accepting edge, until done reads 1. W=WIDTH, T=number of completed divisions.
  - N<2: L=1.
  - Prime: L = 1 + T*(W+2) + 1. N=2 or 3 gives L=2.
  - Composite: L = 1 + T*(W+2).
- The divisor register never exceeds 2^(WIDTH/2)+1, so no wrap-around. Worst case at WIDTH=16 is N=65521 with 128 trials.

Decomposition:
- Shared package prime_pkg holds:
  - the state enum (IDLE, SQCHK, DIV, DONE)
  - the default WIDTH constant
  - a function giving the trial-division latency, for the bench
- One sub-module, prime_mod_unit, is a restoring remainder engine:
  - ports: clk, rst_n, start, dividend, divisor, valid, remainder
  - 1 load cycle followed by WIDTH shift/subtract cycles
  - valid is a one-cycle pulse on the final cycle
  - divisor is guaranteed >=2 by the parent

Test Plan:
- Small values:
  - N=0 and N=1: done after L=1, is_prime=0, factor=0.
  - N=2: done after L=2, is_prime=1, factor=0.
- N=7 (WIDTH=16) -> one trial (d=2), then 9>7; done at L=20, is_prime=1; stop_counter rises with done.
- N=9 -> trials d=2 and d=3; done at L=37, is_prime=0, factor=3.
- Large values:
  - N=65521: is_prime=1, L=1+128*18+1=2306.
  - N=65535: factor=3.
  - N=4: factor=2, L=19.
- start pulsed again during DIV for N=9 -> ignored, result unchanged. Then start with N=13 while in DONE -> done/stop_counter fall on that edge; result is_prime=1.
- rst_n low mid-DIV for 1 cycle -> all outputs 0 asynchronously. A following start with N=25 gives factor=5, is_prime=0.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and constants for the trial-division prime tester.
package prime_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSqchk,
    StDiv,
    StDone
  } state_e;

  // Edges from the accepting edge until done reads 1, for a datapath of the given width.
  function automatic int unsigned trial_latency(input int unsigned n, input int unsigned width);
    int unsigned d;
    int unsigned t;
    if (n < 2) return 1;
    d = 2;
    t = 0;
    while (d * d <= n) begin
      t++;
      if (n % d == 0) return 1 + t * (width + 2);
      d = (d == 2) ? 3 : d + 2;
    end
    return 2 + t * (width + 2);
  endfunction

endpackage

// File: rtl/prime_mod_unit.sv
// Restoring remainder engine: one load cycle, then WIDTH shift/subtract cycles.
module prime_mod_unit
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic [WIDTH:0]   trial;

  // Partial remainder with the next dividend bit brought down.
  assign trial = {rem_q, shift_q[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        rem_q   <= '0;
        shift_q <= dividend;
        cnt_q   <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
        shift_q <= {shift_q[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
          rem_q <= WIDTH'(trial - {1'b0, divisor});
        end else begin
          rem_q <= WIDTH'(trial);
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) valid_q <= 1'b1;
      end
    end
  end

  assign valid     = valid_q;
  assign remainder = rem_q;

endmodule

// File: rtl/prime_trial_divider.sv
// Sequential trial-division prime tester; stop_counter freezes the seconds counter once done.
module prime_trial_divider
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] test_number,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor,
  output logic             stop_counter
);

  state_e             state;
  logic [WIDTH-1:0]   n_q;
  logic [WIDTH-1:0]   d_q;
  logic [2*WIDTH-1:0] d_sq;
  logic               sq_over;
  logic               mod_start;
  logic               mod_valid;
  logic [WIDTH-1:0]   mod_rem;

  // Full-width square so large divisors cannot wrap.
  assign d_sq      = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign sq_over   = d_sq > {{WIDTH{1'b0}}, n_q};
  assign mod_start = (state == StSqchk) && !sq_over;

  prime_mod_unit #(
    .WIDTH(WIDTH)
  ) u_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mod_start),
    .dividend (n_q),
    .divisor  (d_q),
    .valid    (mod_valid),
    .remainder(mod_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      n_q      <= '0;
      d_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_prime <= 1'b0;
      factor   <= '0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            n_q      <= test_number;
            d_q      <= WIDTH'(2);
            done     <= 1'b0;
            is_prime <= 1'b0;
            factor   <= '0;
            if (test_number < WIDTH'(2)) begin
              state <= StDone;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= StSqchk;
              busy  <= 1'b1;
            end
          end
        end
        StSqchk: begin
          if (sq_over) begin
            state    <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            is_prime <= 1'b1;
            factor   <= '0;
          end else begin
            state <= StDiv;
          end
        end
        StDiv: begin
          if (mod_valid) begin
            if (mod_rem == '0) begin
              state    <= StDone;
              busy     <= 1'b0;
              done     <= 1'b1;
              is_prime <= 1'b0;
              factor   <= d_q;
            end else begin
              d_q   <= (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
              state <= StSqchk;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign stop_counter = done;

endmodule

// File: tb/tb_prime_trial_divider.sv
// Self-checking bench for prime_trial_divider against a trial-division reference model.
module tb_prime_trial_divider;

  localparam int W = 16;
  localparam int MAX_EDGES = 5000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] test_number = '0;
  logic         busy;
  logic         done;
  logic         is_prime;
  logic [W-1:0] factor;
  logic         stop_counter;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prime_trial_divider #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .test_number (test_number),
    .busy        (busy),
    .done        (done),
    .is_prime    (is_prime),
    .factor      (factor),
    .stop_counter(stop_counter)
  );

  // Reference: divide by 2,3,5,7,... while d*d <= n; each completed division costs W+2 edges.
  function automatic void model(input int n, output bit p, output int f, output int lat);
    int d;
    int t;
    if (n < 2) begin
      p = 0; f = 0; lat = 1;
      return;
    end
    d = 2;
    t = 0;
    forever begin
      if (d * d > n) begin
        p = 1; f = 0; lat = 2 + t * (W + 2);
        return;
      end
      t++;
      if (n % d == 0) begin
        p = 0; f = d; lat = 1 + t * (W + 2);
        return;
      end
      d = (d == 2) ? 3 : d + 2;
    end
  endfunction

  // Pulse start with n, scramble test_number while busy, count edges until done.
  task automatic apply(input int n, output int lat, output bit ok);
    @(negedge clk);
    start = 1'b1;
    test_number = W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    test_number = W'($urandom);
    lat = 1;
    ok = 1;
    while (!done) begin
      if (lat >= MAX_EDGES) begin
        ok = 0;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, is_prime, stop_counter, factor} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b prime=%b stop=%b factor=%0d, want all 0",
               busy, done, is_prime, stop_counter, factor);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int nums[8] = '{0, 1, 2, 7, 9, 65521, 65535, 4};
    for (int i = 0; i < 8; i++) begin
      bit ep, ok;
      int ef, el, lat;
      model(nums[i], ep, ef, el);
      apply(nums[i], lat, ok);
      vectors++;
      if (!ok || lat != el) begin
        miscompares++;
        $display("FAIL latency n=%0d: got %0d (ok=%0d), want %0d", nums[i], lat, ok, el);
      end
      vectors++;
      if (is_prime !== ep || factor !== W'(ef)) begin
        miscompares++;
        $display("FAIL result n=%0d: got prime=%b factor=%0d, want prime=%b factor=%0d",
                 nums[i], is_prime, factor, ep, ef);
      end
      vectors++;
      if (stop_counter !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL done_flags n=%0d: got stop=%b busy=%b, want stop=1 busy=0",
                 nums[i], stop_counter, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      bit ep, ok;
      int ef, el, lat, n;
      n = int'($urandom_range(0, 65535));
      model(n, ep, ef, el);
      apply(n, lat, ok);
      vectors++;
      if (!ok || lat != el || is_prime !== ep || factor !== W'(ef)) begin
        miscompares++;
        $display("FAIL random n=%0d: got lat=%0d prime=%b factor=%0d, want lat=%0d prime=%b factor=%0d",
                 n, lat, is_prime, factor, el, ep, ef);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ep;
    int ef, el, lat;
    // N=9 with stray starts during both divisions.
    model(9, ep, ef, el);
    @(negedge clk);
    start = 1'b1;
    test_number = W'(9);
    @(posedge clk);
    #1;
    lat = 1;
    while (!done && lat < MAX_EDGES) begin
      @(negedge clk);
      start = (lat == 5 || lat == 25);
      test_number = W'(100);
      @(posedge clk);
      #1;
      lat++;
      if (lat == 6) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_mid: got %b, want 1", busy);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (!done || lat != el || is_prime !== ep || factor !== W'(ef)) begin
      miscompares++;
      $display("FAIL ignore_start: got done=%b lat=%0d prime=%b factor=%0d, want lat=%0d prime=%b factor=%0d",
               done, lat, is_prime, factor, el, ep, ef);
    end
    // Restart from DONE with N=13: done/stop_counter drop on the accepting edge.
    model(13, ep, ef, el);
    @(negedge clk);
    start = 1'b1;
    test_number = W'(13);
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || stop_counter !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_edge: got done=%b stop=%b busy=%b, want 0 0 1",
               done, stop_counter, busy);
    end
    lat = 1;
    while (!done && lat < MAX_EDGES) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (!done || lat != el || is_prime !== ep || factor !== W'(ef)) begin
      miscompares++;
      $display("FAIL restart_result: got done=%b lat=%0d prime=%b factor=%0d, want lat=%0d prime=%b factor=%0d",
               done, lat, is_prime, factor, el, ep, ef);
    end
  endtask

  task automatic test_abort();
    bit ep, ok;
    int ef, el, lat;
    @(negedge clk);
    start = 1'b1;
    test_number = W'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, is_prime, stop_counter, factor} !== '0) begin
      miscompares++;
      $display("FAIL async_abort: got busy=%b done=%b prime=%b stop=%b factor=%0d, want all 0",
               busy, done, is_prime, stop_counter, factor);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(25, ep, ef, el);
    apply(25, lat, ok);
    vectors++;
    if (!ok || lat != el || is_prime !== ep || factor !== W'(ef)) begin
      miscompares++;
      $display("FAIL after_abort: got lat=%0d prime=%b factor=%0d, want lat=%0d prime=%b factor=%0d",
               lat, is_prime, factor, el, ep, ef);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
